// File: rtl/sram_bus_pkg.sv
// ============================================================================
//  Module      : sram_bus_pkg
//  Description : Shared defaults and port-0 state encoding for the SRAM bus
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_bus_pkg;

    localparam int c_addr_width = 9;
    localparam int c_data_width = 32;
    localparam int c_num_wmasks = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } p0_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_dbg_rport.sv
// ============================================================================
//  Module      : sram_dbg_rport
//  Description : Debug read channel on the macro read-only port: request
//                latch, one-cycle csb1 pulse, two-stage ack pipeline, stall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_dbg_rport
    import sram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic                  stall,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    logic r_pend;
    logic r_wait;
    logic w_busy;

    // New requests are ignored from acceptance until the ack cycle is over.
    assign w_busy = r_pend | ~sram_csb1 | r_wait | dbg_ack;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend     <= 1'b0;
            r_wait     <= 1'b0;
            sram_csb1  <= 1'b1;
            sram_addr1 <= '0;
            dbg_ack    <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            sram_csb1 <= 1'b1;
            r_pend    <= 1'b0;
            r_wait    <= ~sram_csb1;
            dbg_ack   <= r_wait;
            if (r_wait) begin
                dbg_rdata <= sram_dout1;
            end
            if (r_pend) begin
                sram_csb1 <= 1'b0;
            end else if (dbg_req && !w_busy) begin
                // Address is loaded even when stalled; csb1 high keeps it inert.
                sram_addr1 <= dbg_addr;
                if (stall) begin
                    r_pend <= 1'b1;
                end else begin
                    sram_csb1 <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_bus_ctrl.sv
// ============================================================================
//  Module      : sram_bus_ctrl
//  Description : picosoc native bus to dual-port SRAM macro bridge with a
//                debug read channel on the macro read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bus_ctrl
    import sram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width,
    parameter int NUM_WMASKS = c_num_wmasks
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [31:0]           mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [NUM_WMASKS-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  sel,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    p0_state_t             r_state;
    logic                  w_req;
    logic                  w_dbg_stall;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic                  w_unused_addr;

    assign w_word_addr   = mem_addr[ADDR_WIDTH+1:2];
    assign w_unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};
    assign w_req         = mem_valid & sel;

    // A write about to start on the same word would race a debug read issued
    // on the same edge, so the debug issue is held back one cycle.
    assign w_dbg_stall = (r_state == IDLE) & w_req & (|mem_wstrb) &
                         (w_word_addr == dbg_addr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        sram_csb0  <= 1'b0;
                        sram_addr0 <= w_word_addr;
                        if (|mem_wstrb) begin
                            sram_web0   <= 1'b0;
                            sram_wmask0 <= mem_wstrb;
                            sram_din0   <= mem_wdata;
                        end else begin
                            sram_web0   <= 1'b1;
                            sram_wmask0 <= '0;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                    if (!sram_web0) begin
                        mem_ready <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    mem_rdata <= sram_dout0;
                    mem_ready <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    mem_ready <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sram_dbg_rport #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dbg_rport (
        .clk        (clk),
        .resetn     (resetn),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .stall      (w_dbg_stall),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

endmodule

`default_nettype wire

// File: doc/sram_bus_ctrl.md
SRAM_BUS_CTRL -- requirements
Module: sram_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width in bits.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, one byte-mask bit per 8 data bits.
REQ-004 SHALL have port clk, input, 1, single clock for the block and both SRAM macro ports.
REQ-005 SHALL have port resetn, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have ports mem_valid (in, 1), mem_ready (out, 1), mem_addr (in, 32, byte address), mem_wdata (in, DATA_WIDTH), mem_wstrb (in, NUM_WMASKS), mem_rdata (out, DATA_WIDTH): picosoc native bus.
REQ-007 SHALL have port sel, input, 1, region select decoded by the parent; a request is mem_valid & sel.
REQ-008 SHALL have ports sram_csb0, sram_web0 (out, 1, active-low), sram_wmask0 (out, NUM_WMASKS), sram_addr0 (out, ADDR_WIDTH), sram_din0 (out, DATA_WIDTH), sram_dout0 (in, DATA_WIDTH): macro RW port.
REQ-009 SHALL have ports dbg_req (in, 1), dbg_addr (in, ADDR_WIDTH), dbg_ack (out, 1), dbg_rdata (out, DATA_WIDTH), sram_csb1 (out, 1, active-low), sram_addr1 (out, ADDR_WIDTH), sram_dout1 (in, DATA_WIDTH): debug read channel on the macro R port.

Function
REQ-010 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-011 Port-0 FSM SHALL have states IDLE, ACCESS, WAIT, RESP.
REQ-012 IDLE: on a request, SHALL load sram_addr0 = mem_addr[ADDR_WIDTH+1:2], sram_csb0 = 0, and go to ACCESS; mem_addr[1:0] and upper bits SHALL be ignored.
REQ-013 Write (mem_wstrb != 0): SHALL drive sram_web0 = 0, sram_wmask0 = mem_wstrb, sram_din0 = mem_wdata; ACCESS -> RESP with mem_ready = 1 in RESP; write latency = 2 cycles from request to ready.
REQ-014 Read (mem_wstrb == 0): SHALL drive sram_web0 = 1, sram_wmask0 = 0; ACCESS -> WAIT -> RESP; mem_rdata SHALL capture sram_dout0 on entry to RESP; read latency = 3 cycles.
REQ-015 sram_csb0 SHALL return to 1 on leaving ACCESS; it SHALL be low for exactly one cycle per request.
REQ-016 mem_ready SHALL be high for exactly one cycle (RESP); RESP -> IDLE unconditionally.
REQ-017 mem_rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-018 mem_valid deasserting mid-transaction SHALL NOT abort it; the SRAM access completes and ready still pulses.
REQ-019 mem_valid & !sel SHALL be ignored entirely.
REQ-020 Debug channel: dbg_req sampled high while idle SHALL drive sram_csb1 = 0, sram_addr1 = dbg_addr for one cycle; dbg_rdata SHALL capture sram_dout1 and dbg_ack SHALL pulse one cycle 2 cycles after csb1 low.
REQ-021 dbg_req arriving while a debug read is in flight SHALL be ignored until dbg_ack has pulsed.
REQ-022 Hazard: if a debug read would issue in the same cycle sram_csb0 = 0 & sram_web0 = 0 with equal address, the debug issue SHALL be stalled one cycle and then issue.

Reset
REQ-023 On resetn low, SHALL asynchronously force: FSM IDLE, debug idle, sram_csb0 = sram_csb1 = sram_web0 = 1, sram_wmask0 = 0, sram_addr0 = sram_addr1 = 0, sram_din0 = 0, mem_ready = 0, dbg_ack = 0, mem_rdata = dbg_rdata = 0.
REQ-024 Reset mid-transaction SHALL abandon it; no mem_ready or dbg_ack SHALL be produced for it after release.

Structure
REQ-025 Package sram_bus_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS defaults and the port-0 state enum.
REQ-026 The debug channel SHALL be a sub-module sram_dbg_rport (request latch, csb1 pulse, ack pipeline, stall input).

Verification
REQ-027 Write mem_addr = 0x0000_0010, wdata = 0xDEAD_BEEF, wstrb = 4'hF -> sram_addr0 = 4, csb0 = 0, web0 = 0 one cycle, mem_ready 2 cycles after request.
REQ-028 Read same address with macro model returning 0xDEAD_BEEF -> mem_rdata = 0xDEAD_BEEF with mem_ready 3 cycles after request, one-cycle pulse.
REQ-029 Byte write wstrb = 4'b0100, wdata = 0x00AB_0000 to addr 0x14 -> wmask0 = 4'b0100; readback = 0x00AB_0000 over zero-initialised word.
REQ-030 dbg_req at addr 5 concurrent with port-0 write to addr 5 -> csb1 delayed one cycle; dbg_ack 3 cycles after dbg_req with post-write data.
REQ-031 resetn low during WAIT of a read -> all outputs at REQ-023 values immediately; no mem_ready after release; next request completes normally.
REQ-032 mem_valid = 1, sel = 0 for 10 cycles -> csb0 stays 1, mem_ready stays 0.
